// File: rtl/sample_fetcher.sv
// Consumer side of the oscillator sample handshake: requests one sample per frame
// tick, scales it by a 4-bit volume and presents it via a one-entry valid/ready slot.
module sample_fetcher #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  output logic        gen_next,
  input  logic        gen_ready,
  input  logic [15:0] gen_sample,
  input  logic [3:0]  volume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sample,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clear_flags
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  // The counter is 0 in the first WAIT cycle, so the last allowed WAIT cycle sees TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic [7:0]         wait_cnt;
  logic [15:0]        hold_sample;

  logic signed [20:0] product;
  logic [15:0]        scaled;
  logic [15:0]        cap_value;
  logic               capture;
  logic               timeout_hit;
  logic               slot_free;
  logic               tick_drop;
  logic               load;
  logic               unused_product;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    capture     = 1'b0;
    timeout_hit = 1'b0;
    product     = $signed({{5{gen_sample[15]}}, gen_sample}) * $signed({17'd0, volume});
    scaled      = product[19:4];
    cap_value   = scaled;

    // A response in the final WAIT cycle wins over the timeout.
    if (state == WAIT) begin
      if (gen_ready) begin
        capture = 1'b1;
      end else if (wait_cnt == WAIT_LAST) begin
        capture     = 1'b1;
        timeout_hit = 1'b1;
        cap_value   = '0;
      end
    end

    slot_free = !out_valid || out_ready;
    tick_drop = frame_tick && (state != IDLE);
    load      = slot_free && (capture || (state == HOLD));
  end

  // Sign bit and fraction of the product are never needed: the shifted result cannot overflow.
  assign unused_product = ^{product[20], product[3:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      // NOTE: the hold register is reset too, so nothing stale can surface after reset.
      hold_sample <= '0;
      gen_next    <= 1'b0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      gen_next <= (state == IDLE) && frame_tick;

      if (tick_drop)        overrun <= 1'b1;
      else if (clear_flags) overrun <= 1'b0;

      if (timeout_hit)      timeout_err <= 1'b1;
      else if (clear_flags) timeout_err <= 1'b0;

      // Pass-through: a reload in the accepting cycle keeps out_valid high with no bubble.
      if (load) begin
        out_valid  <= 1'b1;
        out_sample <= (state == HOLD) ? hold_sample : cap_value;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: if (frame_tick) state <= REQ;
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (capture) begin
            if (slot_free) begin
              state <= IDLE;
            end else begin
              hold_sample <= cap_value;
              state       <= HOLD;
            end
          end
        end
        HOLD: if (slot_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fetcher.sv
// Bench for sample_fetcher: a cycle-age reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sample_fetcher;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        gen_next;
  logic        gen_ready;
  logic [15:0] gen_sample;
  logic [3:0]  volume;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic        overrun;
  logic        timeout_err;
  logic        clear_flags;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  sample_fetcher #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .gen_next    (gen_next),
    .gen_ready   (gen_ready),
    .gen_sample  (gen_sample),
    .volume      (volume),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .clear_flags (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor of sample * volume / 16 computed with plain integer arithmetic.
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] v);
    int p;
    p = int'($signed(s)) * int'(v);
    return 16'(p >>> 4);
  endfunction

  // Reference model: a fetch is tracked by its age in cycles since the accepted tick.
  bit          m_busy, m_held, m_gen_next, m_valid, m_ovr, m_to;
  int          m_age;
  logic [15:0] m_hval, m_sample;

  always @(posedge clk or negedge reset_n) begin
    bit          got, free, ld, accept;
    logic [15:0] val, ld_val;
    if (!reset_n) begin
      m_busy = 0; m_held = 0; m_gen_next = 0; m_valid = 0; m_ovr = 0; m_to = 0;
      m_age = 0; m_hval = '0; m_sample = '0;
    end else begin
      got = 0; ld = 0; val = '0; ld_val = '0;
      accept = frame_tick && !m_busy && !m_held;
      free   = !m_valid || out_ready;
      if (m_busy && m_age >= 2 && gen_ready) begin
        got = 1; val = scale(gen_sample, volume);
      end else if (m_busy && m_age == TIMEOUT + 1) begin
        got = 1; val = '0; m_to = 1;
      end else if (clear_flags) begin
        m_to = 0;
      end
      if (frame_tick && (m_busy || m_held)) m_ovr = 1;
      else if (clear_flags)                 m_ovr = 0;
      if (m_held && free) begin
        ld = 1; ld_val = m_hval; m_held = 0;
      end
      if (got) begin
        m_busy = 0;
        if (free) begin ld = 1; ld_val = val; end
        else begin m_held = 1; m_hval = val; end
      end else if (m_busy) begin
        m_age++;
      end
      m_gen_next = accept;
      if (accept) begin m_busy = 1; m_age = 1; end
      if (ld) begin m_valid = 1; m_sample = ld_val; end
      else if (m_valid && out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gen_next",    16'(gen_next),    16'(m_gen_next));
      check("out_valid",   16'(out_valid),   16'(m_valid));
      check("out_sample",  out_sample,       m_sample);
      check("overrun",     16'(overrun),     16'(m_ovr));
      check("timeout_err", 16'(timeout_err), 16'(m_to));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick in cycle 0, reader answers in cycle 3; returns at the start of cycle 4.
  task automatic fetch(input logic [15:0] s, input logic [3:0] v);
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step();
    step(); gen_ready = 1'b1; gen_sample = s; volume = v;
    step(); gen_ready = 1'b0; gen_sample = '0;
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; gen_ready = 1'b0; gen_sample = '0;
    volume = 4'd8; out_ready = 1'b1; clear_flags = 1'b0;

    check("scale_min_max", scale(16'h8000, 4'd15), 16'h8800);
    check("scale_floor",   scale(16'hFFFF, 4'd1),  16'hFFFF);
    check("scale_half",    scale(16'h4000, 4'd8),  16'h2000);

    step(); step();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    #3;
    check("rst_out_valid",  16'(out_valid),  16'd0);
    check("rst_out_sample", out_sample,      16'd0);
    check("rst_gen_next",   16'(gen_next),   16'd0);
    check("rst_flags",      16'({overrun, timeout_err}), 16'd0);

    // Basic fetch
    step(); frame_tick = 1'b1; #3 check("basic_gn_c0", 16'(gen_next), 16'd0);
    step(); frame_tick = 1'b0; #3 check("basic_gn_c1", 16'(gen_next), 16'd1);
    step(); #3 check("basic_gn_c2", 16'(gen_next), 16'd0);
    step(); gen_ready = 1'b1; gen_sample = 16'h4000; #3 check("basic_ov_c3", 16'(out_valid), 16'd0);
    step(); gen_ready = 1'b0; #3;
    check("basic_ov_c4", 16'(out_valid), 16'd1);
    check("basic_os_c4", out_sample, 16'h2000);
    check("basic_flags", 16'({overrun, timeout_err}), 16'd0);

    // Signed scaling
    fetch(16'h1234, 4'd0);  #3 check("scale_vol0",  out_sample, 16'h0000);
    fetch(16'hFFFF, 4'd1);  #3 check("scale_m1",    out_sample, 16'hFFFF);
    fetch(16'h8000, 4'd15); #3 check("scale_min15", out_sample, 16'h8800);

    // Timeout: no response; zero sample and flag in cycle TIMEOUT+2
    volume = 4'd8;
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    repeat (TIMEOUT) step();
    #3 check("to_c9_flag", 16'(timeout_err), 16'd0);
    step(); #3;
    check("to_c10_flag",  16'(timeout_err), 16'd1);
    check("to_c10_valid", 16'(out_valid),   16'd1);
    check("to_c10_zero",  out_sample,       16'h0000);
    step();
    step(); gen_ready = 1'b1; gen_sample = 16'h7777;
    step(); gen_ready = 1'b0; #3;
    check("to_late_valid",  16'(out_valid), 16'd0);
    check("to_late_sample", out_sample,     16'h0000);
    step(); clear_flags = 1'b1;
    step(); clear_flags = 1'b0; #3 check("to_cleared", 16'(timeout_err), 16'd0);

    // Backpressure: second sample waits in HOLD, then passes through with no bubble
    out_ready = 1'b0;
    fetch(16'h2000, 4'd8); #3 check("bp_first", out_sample, 16'h1000);
    fetch(16'h4000, 4'd8); #3 check("bp_stable", out_sample, 16'h1000);
    step(); #3 check("bp_stable2", out_sample, 16'h1000);
    step(); out_ready = 1'b1; #3 check("bp_accept_valid", 16'(out_valid), 16'd1);
    step(); out_ready = 1'b0; #3;
    check("bp_next_valid",  16'(out_valid), 16'd1);
    check("bp_next_sample", out_sample,     16'h2000);
    step(); out_ready = 1'b1;
    fetch(16'h0100, 4'd8); #3;
    check("bp_idle_sample", out_sample,   16'h0080);
    check("bp_no_overrun",  16'(overrun), 16'd0);

    // Overrun: second tick in cycle 2 is dropped
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0; #3 check("ovr_gn_c1", 16'(gen_next), 16'd1);
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0; gen_ready = 1'b1; gen_sample = 16'h0100; #3;
    check("ovr_flag_c3", 16'(overrun),  16'd1);
    check("ovr_gn_c3",   16'(gen_next), 16'd0);
    step(); gen_ready = 1'b0; #3 check("ovr_out_c4", 16'(out_valid), 16'd1);
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step(); frame_tick = 1'b1; clear_flags = 1'b1;
    step(); frame_tick = 1'b0; clear_flags = 1'b0; gen_ready = 1'b1; gen_sample = 16'h0200; #3;
    check("ovr_set_wins", 16'(overrun), 16'd1);
    step(); gen_ready = 1'b0; clear_flags = 1'b1;
    step(); clear_flags = 1'b0; #3 check("ovr_cleared", 16'(overrun), 16'd0);

    // Reset mid-WAIT with a pending output and a set flag
    out_ready = 1'b0;
    fetch(16'h4000, 4'd8);
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0; #1;
    reset_n = 1'b0; #1;
    check("rst_mid_valid",  16'(out_valid),  16'd0);
    check("rst_mid_sample", out_sample,      16'd0);
    check("rst_mid_flags",  16'({overrun, timeout_err, gen_next}), 16'd0);
    step(); reset_n = 1'b1; gen_ready = 1'b1; gen_sample = 16'h7000;
    step(); gen_ready = 1'b0; #3;
    check("rst_late_valid", 16'(out_valid), 16'd0);
    step(); step(); #3 check("rst_late_sample", out_sample, 16'd0);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
